// File: rtl/arbitro_rr_rafaga_pkg.sv
// arbitro_rr_rafaga_pkg: shared state codes and sizes for the burst round-robin arbiter
package arbitro_rr_rafaga_pkg;
  localparam int NUM_SRC = 4;
  localparam int DEST_W = 2;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SERVE = 2'd1} state_t;
endpackage

// File: rtl/arbitro_rr_rafaga_rr_selector.sv
// rr_selector: combinational rotate-priority finder, first eligible source at or after start
module rr_selector
  import arbitro_rr_rafaga_pkg::*;
(
  input  logic [NUM_SRC-1:0] elig_i,
  input  logic [DEST_W-1:0]  start_i,
  output logic               found_o,
  output logic [DEST_W-1:0]  idx_o
);
  logic [DEST_W-1:0] cand;
  // scan from the farthest offset down so the nearest eligible source wins
  always_comb begin
    found_o = 1'b0;
    idx_o = '0;
    cand = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      cand = start_i + DEST_W'(k);
      if (elig_i[cand]) begin
        found_o = 1'b1;
        idx_o = cand;
      end
    end
  end
endmodule

// File: rtl/arbitro_rr_rafaga.sv
// arbitro_rr_rafaga: burst round-robin arbiter moving words from 4 source FIFOs to 4 destination FIFOs
module arbitro_rr_rafaga
  import arbitro_rr_rafaga_pkg::*;
#(
  parameter int BURST = 4,
  parameter int CNT_W = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [NUM_SRC-1:0]          fifo_empty_i,
  input  logic [NUM_SRC-1:0]          almost_full_i,
  input  logic [NUM_SRC*DEST_W-1:0]   dest_vec_i,
  output logic [NUM_SRC-1:0]          pop_o,
  output logic [NUM_SRC-1:0]          push_o,
  output logic [DEST_W-1:0]           grant_id_o,
  output logic                        busy_o,
  output logic [CNT_W-1:0]            pop_count_o
);
  state_t state_q, state_d;
  logic [DEST_W-1:0] ptr_q, ptr_d, grant_q, start, idx, sel, dsel;
  logic [3:0] burst_q, burst_d, cnt_nxt;
  logic [CNT_W-1:0] count_q;
  logic [NUM_SRC-1:0] elig;
  logic serve, cont, found, take, last;
  // a source is eligible only if it has data and its head's destination can accept it
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_SRC; i++)
      elig[i] = !fifo_empty_i[i] && !almost_full_i[dest_vec_i[DEST_W*i +: DEST_W]];
  end
  assign serve = state_q == ST_SERVE;
  assign cont = serve && elig[ptr_q] && burst_q < 4'(BURST);
  assign start = serve ? ptr_q + 2'd1 : ptr_q;
  rr_selector u_sel (
    .elig_i (elig),
    .start_i(start),
    .found_o(found),
    .idx_o  (idx)
  );
  assign take = !reset_i && (cont || found);
  assign sel = cont ? ptr_q : idx;
  assign cnt_nxt = cont ? burst_q + 4'd1 : 4'd1;
  assign last = cnt_nxt == 4'(BURST);
  // next state: keep serving until the burst fills, then hand the pointer to the following source
  always_comb begin
    state_d = take && !last ? ST_SERVE : ST_IDLE;
    ptr_d = !take ? ptr_q : last ? sel + 2'd1 : sel;
    burst_d = take && !last ? cnt_nxt : 4'd0;
  end
  // zero-latency transfer strobes in the decision cycle
  always_comb begin
    dsel = dest_vec_i[DEST_W*sel +: DEST_W];
    pop_o = take ? 4'b0001 << sel : 4'b0000;
    push_o = take ? 4'b0001 << dsel : 4'b0000;
  end
  // state, pointer, burst counter and registered status outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      ptr_q <= '0;
      burst_q <= '0;
      grant_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      burst_q <= burst_d;
      grant_q <= take ? sel : grant_q;
      count_q <= count_q + CNT_W'(take);
    end
  end
  assign grant_id_o = grant_q;
  assign busy_o = serve;
  assign pop_count_o = count_q;
endmodule

// File: tb/tb_arbitro_rr_rafaga.sv
// tb_arbitro_rr_rafaga: directed scenarios plus a per-cycle protocol monitor for the burst arbiter
module tb_arbitro_rr_rafaga;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] fifo_empty = 4'b0000;
  logic [3:0] almost_full = 4'b0000;
  logic [7:0] dest_vec = 8'h00;
  logic [3:0] pop, push;
  logic [1:0] grant_id;
  logic busy;
  logic [7:0] pop_count;
  logic [7:0] model = 8'd0;
  int checks = 0;
  int errors = 0;

  arbitro_rr_rafaga #(.BURST(4), .CNT_W(8)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .fifo_empty_i (fifo_empty),
    .almost_full_i(almost_full),
    .dest_vec_i   (dest_vec),
    .pop_o        (pop),
    .push_o       (push),
    .grant_id_o   (grant_id),
    .busy_o       (busy),
    .pop_count_o  (pop_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    checks++;
    if (!$onehot0(pop) || !$onehot0(push) || $countones(pop) != $countones(push)) begin
      errors++;
      $display("FAIL mon_onehot pop=%b push=%b required onehot0 with equal counts", pop, push);
    end
    checks++;
    if ((pop & fifo_empty) != 4'b0000) begin
      errors++;
      $display("FAIL mon_pop_empty pop=%b fifo_empty=%b required no overlap", pop, fifo_empty);
    end
    checks++;
    if ((push & almost_full) != 4'b0000) begin
      errors++;
      $display("FAIL mon_push_af push=%b almost_full=%b required no overlap", push, almost_full);
    end
    checks++;
    if (pop_count !== model) begin
      errors++;
      $display("FAIL mon_pop_count got=%0d required=%0d", pop_count, model);
    end
    model = reset ? 8'd0 : model + 8'(pop != 4'b0000);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fifo_empty = 4'b0000;
    almost_full = 4'b0000;
    dest_vec = 8'h00;
    for (int c = 0; c < 2; c++) begin
      cyc();
      #1;
      checks++;
      if (pop !== 4'b0000 || push !== 4'b0000) begin
        errors++;
        $display("FAIL reset_strobes pop=%b push=%b required 0000/0000", pop, push);
      end
      checks++;
      if (pop_count !== 8'd0 || grant_id !== 2'd0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_regs count=%0d grant=%0d busy=%b required 0/0/0", pop_count, grant_id, busy);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_burst();
    int exp_src[17] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};
    for (int i = 0; i < 17; i++) begin
      #1;
      checks++;
      if (pop !== (4'b0001 << exp_src[i]) || push !== 4'b0001) begin
        errors++;
        $display("FAIL burst_seq cycle=%0d pop=%b push=%b required pop src %0d push 0001", i, pop, push, exp_src[i]);
      end
      checks++;
      if (grant_id !== (i == 0 ? 2'd0 : 2'(exp_src[i-1])) || busy !== (i % 4 != 0)) begin
        errors++;
        $display("FAIL burst_regs cycle=%0d grant=%0d busy=%b", i, grant_id, busy);
      end
      cyc();
    end
  endtask

  task automatic test_empty_mid();
    int exp_src[5] = '{1, 1, 1, 1, 2};
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (pop !== 4'b0001) begin
        errors++;
        $display("FAIL empty_pre cycle=%0d pop=%b required 0001", i, pop);
      end
      cyc();
    end
    fifo_empty = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (pop !== (4'b0001 << exp_src[i])) begin
        errors++;
        $display("FAIL empty_switch cycle=%0d pop=%b required src %0d", i, pop, exp_src[i]);
      end
      cyc();
    end
  endtask

  task automatic test_almost_full();
    logic [3:0] exp_pop[5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    logic [3:0] exp_push[5] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0100};
    fifo_empty = 4'b1100;
    dest_vec = 8'b0000_1110;
    almost_full = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) almost_full = 4'b0000;
      #1;
      checks++;
      if (pop !== exp_pop[i] || push !== exp_push[i]) begin
        errors++;
        $display("FAIL af_seq cycle=%0d pop=%b push=%b required %b/%b", i, pop, push, exp_pop[i], exp_push[i]);
      end
      cyc();
    end
  endtask

  task automatic test_all_empty();
    logic [3:0] exp_pop[5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    cyc();
    cyc();
    fifo_empty = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (pop !== 4'b0000 || push !== 4'b0000 || pop_count !== 8'd2) begin
        errors++;
        $display("FAIL idle_hold cycle=%0d pop=%b push=%b count=%0d required 0000/0000/2", i, pop, push, pop_count);
      end
      checks++;
      if (busy !== (i == 0)) begin
        errors++;
        $display("FAIL idle_busy cycle=%0d busy=%b required %b", i, busy, i == 0);
      end
      cyc();
    end
    fifo_empty = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (pop !== exp_pop[i]) begin
        errors++;
        $display("FAIL idle_resume cycle=%0d pop=%b required %b", i, pop, exp_pop[i]);
      end
      cyc();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) cyc();
    checks++;
    if (grant_id !== 2'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre grant=%0d busy=%b required 2/1", grant_id, busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (pop !== 4'b0000 || push !== 4'b0000) begin
      errors++;
      $display("FAIL rmid_gate pop=%b push=%b required 0000/0000", pop, push);
    end
    cyc();
    #1;
    checks++;
    if (pop !== 4'b0000 || pop_count !== 8'd0 || grant_id !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_regs pop=%b count=%0d grant=%0d busy=%b required 0000/0/0/0", pop, pop_count, grant_id, busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (pop !== 4'b0001) begin
      errors++;
      $display("FAIL rmid_restart pop=%b required 0001", pop);
    end
    cyc();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 260; i++) begin
      #1;
      checks++;
      if (pop_count !== 8'(i) || pop !== (4'b0001 << ((i / 4) % 4))) begin
        errors++;
        $display("FAIL wrap cycle=%0d count=%0d pop=%b required %0d/src %0d", i, pop_count, pop, i % 256, (i / 4) % 4);
      end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_reset();
    test_empty_mid();
    test_reset();
    test_almost_full();
    test_reset();
    test_all_empty();
    test_reset();
    test_reset_mid();
    test_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
